bcd_seq_addsub: RTL and testbench
=================================

Name: bcd_seq_addsub

Overview:
- Parametrised multi-digit BCD adder/subtractor; successor to the single-digit combinational BCD adder.
- Processes one BCD digit per clock, least-significant digit first, and uses a start/done handshake.
- Used by the lab's calculator/counter datapaths where operands are several BCD digits wide.
- Subtraction uses ten's complement (nine's complement of b plus 1).

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  request an operation; sampled only in IDLE
- sub  input  1  0 = a+b+carry_in, 1 = a-b (carry_in ignored)
- carry_in  input  1  decimal carry into digit 0 (add mode only)
- a  input  4*DIGITS  BCD operand, digit i at bits [4i+3:4i]
- b  input  4*DIGITS  BCD operand
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- sum  output  4*DIGITS  BCD result, held until the next accepted start
- carry_out  output  1  add: decimal carry out; sub: 1 = no borrow (a>=b)
- invalid  output  1  at least one operand digit was >9 for the last operation

Behaviour:
- Reset: rst_n low at a rising clk edge forces state IDLE, digit counter 0, and all outputs to 0 (busy, done, sum, carry_out, invalid). Reset applies at any point, including mid-RUN; the partial result is discarded.
- Accept (IDLE, start=1 at edge T):
  - latch a, b, sub, and the initial carry (sub ? 1 : carry_in);
  - clear sum; set invalid to whether any digit of a or b is >9;
  - next state is DONE if invalid, otherwise RUN.
- RUN covers edges T+1 .. T+DIGITS, one digit per edge (i = 0..DIGITS-1):
  - bd = sub ? (9 - b_i) : b_i;
  - t = a_i + bd + c (5-bit);
  - if t>9: digit = (t+6)[3:0], c = 1; else digit = t[3:0], c = 0;
  - sum digit i is written on that edge.
- After the last digit, go to DONE.
- DONE lasts one cycle: done=1, carry_out = final c, then IDLE.
- Result timing: valid edge-aligned with done, at T+DIGITS+1 (valid case) or T+1 (invalid case).
- Invalid case: sum=0, carry_out=0, invalid=1, no RUN cycles.
- busy=1 exactly during RUN.
- start outside IDLE is ignored (no queueing). start in the DONE cycle is also ignored; start is accepted again from the following IDLE cycle.
- Operands may change after acceptance without effect.
- Outputs hold their values in IDLE. invalid clears only on the next accepted start.
- Subtraction with a<b: sum = ten's complement (10^DIGITS - (b-a)), carry_out=0.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_MAX=9 and BCD_CORR=6;
  - a 2-bit state typedef/encoding IDLE=0, RUN=1, DONE=2.
- One natural sub-module: bcd_digit_add, a combinational single-digit adder with correction (a_i, bd, c -> digit, c_out). It is reused for both modes.
- The counter width is clog2(DIGITS), minimum 1.

Test Plan:
- DIGITS=4, add: a=0x0999, b=0x0001, cin=0, start at T -> busy for 4 cycles; done at T+5; sum=0x1000, carry_out=0, invalid=0.
- Add wrap: a=0x9999, b=0x0000, cin=1 -> sum=0x0000, carry_out=1.
- Sub: a=0x0500, b=0x0123, sub=1 -> sum=0x0377, carry_out=1. Sub: a=0x0123, b=0x0500 -> sum=0x9623, carry_out=0.
- Invalid: a=0x00A0, b=0x0001 -> done at T+1; sum=0, carry_out=0, invalid=1. Next valid op clears invalid.
- start pulsed at T+2 during RUN with different operands -> ignored; the first result is unchanged and done is asserted once.
- rst_n low at T+2 mid-RUN -> next cycle in IDLE with all outputs 0 and no done. A fresh start then completes normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential BCD adder/subtractor.
package bcd_pkg;

    // Largest legal BCD digit and the decimal correction added when a digit sum overflows.
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // Control state of the digit-serial engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// The subtract path feeds the nine's complement of b in as bd_i, so this
// block serves both modes unchanged.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] bd_i,
    input  logic       c_i,
    output logic [3:0] digit_o,
    output logic       c_o
);

    logic [4:0] t;

    // Binary digit sum, then +6 correction whenever the sum leaves the decimal range.
    always_comb begin
        t = {1'b0, a_i} + {1'b0, bd_i} + {4'b0000, c_i};
        if (t > {1'b0, BCD_MAX}) begin
            digit_o = t[3:0] + BCD_CORR;
            c_o     = 1'b1;
        end else begin
            digit_o = t[3:0];
            c_o     = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_addsub.sv
// Digit-serial multi-digit BCD adder/subtractor with a start/done handshake.
// One digit is processed per clock, least-significant first. Subtraction
// uses ten's complement: nine's complement of each b digit with an initial
// carry of 1. Operands are latched on accept and shifted right each RUN
// cycle so the working digit is always in the low nibble.
module bcd_seq_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  carry_in,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry_out,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;
    logic            c_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    sum_q;
    logic            carry_q;
    logic            invalid_q;

    logic [3:0]      bd_d;
    logic [3:0]      digit_d;
    logic            c_d;
    logic            bad_d;
    logic            last_d;

    // True when any digit of the operand lies outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] x);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Operand digit selection for the current cycle and accept-time validity check.
    always_comb begin
        bd_d   = sub_q ? (BCD_MAX - b_q[3:0]) : b_q[3:0];
        bad_d  = has_bad_digit(a) | has_bad_digit(b);
        last_d = (cnt_q == CW'(DIGITS - 1));
    end

    bcd_digit_add u_digit (
        .a_i     (a_q[3:0]),
        .bd_i    (bd_d),
        .c_i     (c_q),
        .digit_o (digit_d),
        .c_o     (c_d)
    );

    // Control FSM with registered handshake outputs and digit-serial datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            c_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        sub_q     <= sub;
                        c_q       <= sub | carry_in;
                        cnt_q     <= '0;
                        sum_q     <= '0;
                        carry_q   <= 1'b0;
                        invalid_q <= bad_d;
                        if (bad_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    sum_q[{cnt_q, 2'b00} +: 4] <= digit_d;
                    c_q   <= c_d;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        carry_q <= c_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign invalid   = invalid_q;

endmodule

// File: tb/tb_bcd_seq_addsub.sv
// Bench for bcd_seq_addsub (DIGITS=4): decimal-arithmetic reference model
// with a per-cycle compare, plus directed vectors with literal expectations.
module tb_bcd_seq_addsub;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic          carry_in = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          carry_out;
    logic          invalid;

    int pass_cnt = 0;
    int total_cnt = 0;

    bcd_seq_addsub #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .carry_in  (carry_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic bit any_bad(input logic [W-1:0] x);
        for (int i = 0; i < D; i++) if (x[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int to_int(input logic [W-1:0] x);
        int v = 0;
        for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    bit            m_busy = 0, m_done = 0, m_co = 0, m_inv = 0, started = 0;
    logic [W-1:0]  m_sum = '0, p_sum = '0;
    bit            p_co = 0;
    int            m_left = 0;

    always @(posedge clk) begin
        int ra, rb, r;
        started = 1;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_co = 0; m_inv = 0; m_sum = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_sum = p_sum; m_co = p_co;
            end
        end else if (start) begin
            m_sum = '0; m_co = 0; m_inv = any_bad(a) || any_bad(b);
            if (m_inv) begin
                m_done = 1;
            end else begin
                ra = to_int(a); rb = to_int(b);
                if (sub) begin
                    r = ra - rb;
                    p_co = (r >= 0);
                    if (r < 0) r = r + 10 ** D;
                end else begin
                    r = ra + rb + int'(carry_in);
                    p_co = (r >= 10 ** D);
                    r = r % (10 ** D);
                end
                p_sum = to_bcd(r);
                m_busy = 1; m_left = D;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("invalid", 32'(invalid), 32'(m_inv));
            if (!m_busy) begin
                chk("sum", 32'(sum), 32'(m_sum));
                chk("carry_out", 32'(carry_out), 32'(m_co));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic ts, input logic tc, input logic [W-1:0] es,
                         input logic eco, input logic einv, input int elat);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; carry_in = tc; start = 1;
        @(negedge clk);
        start = 0; a = W'($urandom); b = W'($urandom); sub = ~ts; carry_in = ~tc;
        wait_done(lat);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_co"}, 32'(carry_out), 32'(eco));
        chk({nm, "_inv"}, 32'(invalid), 32'(einv));
    endtask

    initial begin
        int lat, ndone;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {25'd0, busy, done, carry_out, invalid, 3'd0}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst_n = 1;

        do_op("add_ripple", 16'h0999, 16'h0001, 0, 0, 16'h1000, 0, 0, 5);
        do_op("add_wrap",   16'h9999, 16'h0000, 0, 1, 16'h0000, 1, 0, 5);
        do_op("sub_pos",    16'h0500, 16'h0123, 1, 0, 16'h0377, 1, 0, 5);
        do_op("sub_neg",    16'h0123, 16'h0500, 1, 1, 16'h9623, 0, 0, 5);
        do_op("add_mix",    16'h4567, 16'h5678, 0, 0, 16'h0245, 1, 0, 5);
        do_op("sub_zero",   16'h2024, 16'h2024, 1, 0, 16'h0000, 1, 0, 5);
        do_op("invalid",    16'h00A0, 16'h0001, 0, 0, 16'h0000, 0, 1, 1);
        do_op("after_inv",  16'h0001, 16'h0002, 0, 1, 16'h0004, 0, 0, 5);

        // start during RUN is ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 0; carry_in = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); a = 16'h9999; b = 16'h9999; carry_in = 1; start = 1;
        @(negedge clk); start = 0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                chk("run_start_sum", 32'(sum), 32'h5555);
            end
            @(negedge clk);
        end
        chk("run_start_done_count", 32'(ndone), 32'd1);

        // start held into the DONE cycle is ignored
        @(negedge clk);
        a = 16'h0011; b = 16'h0022; sub = 0; carry_in = 0; start = 1;
        @(negedge clk); start = 0;
        wait_done(lat);
        chk("done_start_sum", 32'(sum), 32'h0033);
        a = 16'h0100; b = 16'h0200; start = 1;
        @(negedge clk); start = 0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("done_start_ignored", 32'(ndone), 32'd0);
        chk("done_start_hold", 32'(sum), 32'h0033);

        // reset in the middle of RUN
        @(negedge clk);
        a = 16'h0777; b = 16'h0111; sub = 0; carry_in = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk);
        chk("midrst_outputs", {27'd0, busy, done, carry_out, invalid, 1'b0}, 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        rst_n = 1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        do_op("after_rst", 16'h0777, 16'h0111, 0, 0, 16'h0888, 0, 0, 5);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
